// File: rtl/game_flow_control.sv
// Top-level game sequencer: serve, play, pause, stage clear, death and win flow.
// Optional build macro STAGE_SELECT_EN enables the start-stage override on sel_en/sel_stage.
module game_flow_control #(
   parameter  int BALL_NUM   = 2,
   parameter  int LIVES      = 3,
   parameter  int STAGE_NUM  = 4,
   parameter  int CLEAR_HOLD = 1000,
   localparam int SW         = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1,
   localparam int LW         = $clog2(LIVES + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                pause_btn,
   input  logic                bm_ready,
   input  logic                bm_empty,
   input  logic [BALL_NUM-1:0] b_dead,
   input  logic                give_ball,
   input  logic                sel_en,
   input  logic [SW-1:0]       sel_stage,
   output logic [2:0]          state,
   output logic [BALL_NUM-1:0] b_active,
   output logic [LW-1:0]       lives,
   output logic [SW-1:0]       stage,
   output logic                bm_load,
   output logic                run,
   output logic                hold_ball,
   output logic                init,
   output logic                dead,
   output logic                win
);

   localparam int CW = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
   localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
   localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_NUM - 1);
   localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_HOLD - 1);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_PLAY  = 3'd3,
      ST_PAUSE = 3'd4,
      ST_CLEAR = 3'd5,
      ST_DEAD  = 3'd6,
      ST_WIN   = 3'd7
   } state_e;

   state_e              state_q, state_d;
   logic [BALL_NUM-1:0] b_active_q, b_active_d;
   logic [LW-1:0]       lives_q, lives_d;
   logic [SW-1:0]       stage_q, stage_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ack_q, ack_d;
   logic                start_q, pause_q;
   logic                start_p, pause_p;
   logic [BALL_NUM-1:0] nxt;
   logic [SW-1:0]       start_stage;

`ifdef STAGE_SELECT_EN
   always_comb begin
      start_stage = '0;
      if (sel_en) start_stage = (sel_stage > STAGE_LAST) ? STAGE_LAST : sel_stage;
   end
`else
   logic unused_sel;
   assign unused_sel  = ^{sel_en, sel_stage};
   assign start_stage = '0;
`endif

   assign start_p = start & ~start_q;
   assign pause_p = pause_btn & ~pause_q;
   // A give_ball pulse re-arms every slot, overriding a death in the same cycle.
   assign nxt = (b_active_q & ~b_dead) | {BALL_NUM{give_ball}};

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d    = state_q;
      b_active_d = b_active_q;
      lives_d    = lives_q;
      stage_d    = stage_q;
      cnt_d      = cnt_q;
      ack_d      = ack_q;
      case (state_q)
         ST_INIT: begin
            b_active_d = '0;
            if (start_p) begin
               state_d = ST_LOAD;
               lives_d = LIVES_INIT;
               stage_d = start_stage;
            end
         end
         ST_LOAD: begin
            if (!bm_ready)  ack_d   = 1'b1;
            else if (ack_q) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            b_active_d = '0;
            if (start_p) begin
               state_d    = ST_PLAY;
               b_active_d = BALL_NUM'(1);
            end
         end
         ST_PLAY: begin
            if (bm_empty && bm_ready) begin
               state_d    = ST_CLEAR;
               b_active_d = '0;
            end else if (nxt == '0) begin
               b_active_d = '0;
               if (lives_q != '0) lives_d = lives_q - LW'(1);
               state_d = (lives_q <= LW'(1)) ? ST_DEAD : ST_WAIT;
            end else begin
               b_active_d = nxt;
               if (pause_p) state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (pause_p) state_d = ST_PLAY;
         end
         ST_CLEAR: begin
            if (cnt_q == CLEAR_LAST) begin
               if (stage_q >= STAGE_LAST) begin
                  state_d = ST_WIN;
               end else begin
                  state_d = ST_LOAD;
                  stage_d = stage_q + SW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DEAD, ST_WIN: begin
            b_active_d = '0;
            if (start_p) begin
               state_d = ST_INIT;
               lives_d = LIVES_INIT;
               stage_d = '0;
            end
         end
         default: state_d = ST_INIT;
      endcase
      // Handshake flag and hold counter restart on every entry to their state.
      if (state_d == ST_LOAD  && state_q != ST_LOAD)  ack_d = 1'b0;
      if (state_d == ST_CLEAR && state_q != ST_CLEAR) cnt_d = '0;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_INIT;
         b_active_q <= '0;
         lives_q    <= LIVES_INIT;
         stage_q    <= '0;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         start_q    <= 1'b0;
         pause_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         b_active_q <= b_active_d;
         lives_q    <= lives_d;
         stage_q    <= stage_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         start_q    <= start;
         pause_q    <= pause_btn;
      end
   end

   // Decoded from state so an asynchronous reset drops bm_load immediately.
   assign state     = state_q;
   assign b_active  = b_active_q;
   assign lives     = lives_q;
   assign stage     = stage_q;
   assign bm_load   = (state_q == ST_LOAD) && !ack_q;
   assign run       = (state_q == ST_PLAY);
   assign hold_ball = (state_q == ST_WAIT);
   assign init      = (state_q == ST_INIT);
   assign dead      = (state_q == ST_DEAD);
   assign win       = (state_q == ST_WIN);

endmodule
